// File: rtl/rect_ctrl_pkg.sv
// Shared video definitions for the rectangle overlay controller: frame size
// defaults, mode encoding and the centre clamp helper.
package rect_ctrl_pkg;

  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int CW        = 10;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_TRACK  = 2'd2,
    ST_COAST  = 2'd3
  } mode_e;

  // Saturate a signed 11-bit candidate centre into [lo, hi].
  function automatic logic [CW-1:0] clamp_coord(input logic signed [CW:0] v,
                                                input logic [CW-1:0] lo,
                                                input logic [CW-1:0] hi);
    if (v < $signed({1'b0, lo}))      return lo;
    else if (v > $signed({1'b0, hi})) return hi;
    else                              return v[CW-1:0];
  endfunction

endpackage

// File: rtl/rect_ctrl_if.sv
// Camera timing, key/tracker inputs and overlay outputs of rect_ctrl.
// Key pulses for left/right carry a _key suffix so they do not collide with the edge outputs.
interface rect_ctrl_if;
  import rect_ctrl_pkg::*;

  logic          per_frame_clken;
  logic          per_frame_href;
  logic          per_frame_vsync;
  logic          rect_up;
  logic          rect_down;
  logic          rect_left_key;
  logic          rect_right_key;
  logic          rect_flag;
  logic          track_valid;
  logic [CW-1:0] track_x;
  logic [CW-1:0] track_y;
  logic [CW-1:0] x_pos;
  logic [CW-1:0] y_pos;
  logic [CW-1:0] rect_left;
  logic [CW-1:0] rect_right;
  logic [CW-1:0] rect_top;
  logic [CW-1:0] rect_bottom;
  logic          rect_en;
  logic          track_mode;

  modport master (
    output per_frame_clken, per_frame_href, per_frame_vsync,
           rect_up, rect_down, rect_left_key, rect_right_key,
           rect_flag, track_valid, track_x, track_y,
    input  x_pos, y_pos, rect_left, rect_right, rect_top, rect_bottom,
           rect_en, track_mode
  );

  modport slave (
    input  per_frame_clken, per_frame_href, per_frame_vsync,
           rect_up, rect_down, rect_left_key, rect_right_key,
           rect_flag, track_valid, track_x, track_y,
    output x_pos, y_pos, rect_left, rect_right, rect_top, rect_bottom,
           rect_en, track_mode
  );

endinterface

// File: rtl/rect_ctrl_pix_coord_cnt.sv
// Pixel coordinate counters with href/vsync edge strobes; x_pos/y_pos label
// the pixel present in the same cycle.
module pix_coord_cnt
  import rect_ctrl_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  input  logic          href,
  input  logic          vsync,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          frame_start,
  output logic          line_end
);

  logic href_d;
  logic vsync_d;

  assign line_end    = href_d & ~href;
  assign frame_start = vsync & ~vsync_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      href_d  <= 1'b0;
      // NOTE: vsync_d resets high so a vsync already high at reset release is not taken as a frame start.
      vsync_d <= 1'b1;
      x_pos   <= '0;
      y_pos   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      href_d  <= href;
      vsync_d <= vsync;
      if (!href)
        x_pos <= '0;
      else if (clken && x_pos != CW'(H_ACT - 1))
        x_pos <= x_pos + 1'b1;
      if (vsync)
        y_pos <= '0;
      else if (line_end && y_pos != CW'(V_ACT - 1))
        y_pos <= y_pos + 1'b1;
    end
  end

endmodule

// File: rtl/rect_ctrl.sv
// Box centre FSM (OFF/MANUAL/TRACK/COAST) with clamped centre arithmetic and
// frame-start shadow registers that publish tear-free box edges.
module rect_ctrl
  import rect_ctrl_pkg::*;
#(
  parameter int H_ACT       = H_ACT_DEF,
  parameter int V_ACT       = V_ACT_DEF,
  parameter int BOX_W       = 64,
  parameter int BOX_H       = 48,
  parameter int MARGIN      = 10,
  parameter int STEP        = 4,
  parameter int LOST_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  rect_ctrl_if.slave bus
);

  localparam logic [CW-1:0] CX_MIN = CW'(BOX_W / 2 + MARGIN);
  localparam logic [CW-1:0] CX_MAX = CW'(H_ACT - 1 - BOX_W / 2 - MARGIN);
  localparam logic [CW-1:0] CY_MIN = CW'(BOX_H / 2 + MARGIN);
  localparam logic [CW-1:0] CY_MAX = CW'(V_ACT - 1 - BOX_H / 2 - MARGIN);
  localparam logic [CW-1:0] HALF_W = CW'(BOX_W / 2);
  localparam logic [CW-1:0] HALF_H = CW'(BOX_H / 2);
  localparam logic signed [CW:0] STEP_S = (CW + 1)'(STEP);
  localparam int LW = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;

  logic frame_start;
  logic line_end;

  pix_coord_cnt #(.H_ACT(H_ACT), .V_ACT(V_ACT)) u_coord (
    .clk         (clk),
    .rst         (rst),
    .clken       (bus.per_frame_clken),
    .href        (bus.per_frame_href),
    .vsync       (bus.per_frame_vsync),
    .x_pos       (bus.x_pos),
    .y_pos       (bus.y_pos),
    .frame_start (frame_start),
    .line_end    (line_end)
  );

  mode_e           state;
  logic [CW-1:0]   cx, cy;
  logic [LW-1:0]   lost_cnt;
  logic            track_seen;
  logic            load_q;
  logic signed [CW:0] dx, dy;
  logic [CW-1:0]   cx_key, cy_key, cx_trk, cy_trk;

  // Opposing keys cancel; orthogonal keys act independently.
  assign dx = (bus.rect_right_key == bus.rect_left_key) ? '0 :
              bus.rect_right_key ? STEP_S : -STEP_S;
  assign dy = (bus.rect_down == bus.rect_up) ? '0 :
              bus.rect_down ? STEP_S : -STEP_S;

  assign cx_key = clamp_coord($signed({1'b0, cx}) + dx, CX_MIN, CX_MAX);
  assign cy_key = clamp_coord($signed({1'b0, cy}) + dy, CY_MIN, CY_MAX);
  assign cx_trk = clamp_coord($signed({1'b0, bus.track_x}), CX_MIN, CX_MAX);
  assign cy_trk = clamp_coord($signed({1'b0, bus.track_y}), CY_MIN, CY_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_OFF;
      cx         <= CW'(H_ACT / 2);
      cy         <= CW'(V_ACT / 2);
      lost_cnt   <= '0;
      track_seen <= 1'b0;
    end else begin
      track_seen <= frame_start ? bus.track_valid : (track_seen | bus.track_valid);
      if (!bus.rect_flag) begin
        state <= ST_OFF;
      end else begin
        unique case (state)
          ST_OFF, ST_MANUAL: begin
            if (bus.track_valid) begin
              state <= ST_TRACK;
              cx    <= cx_trk;
              cy    <= cy_trk;
            end else begin
              state <= ST_MANUAL;
              cx    <= cx_key;
              cy    <= cy_key;
            end
          end
          ST_TRACK: begin
            if (bus.track_valid) begin
              cx <= cx_trk;
              cy <= cy_trk;
            end else if (frame_start && !track_seen) begin
              state    <= ST_COAST;
              lost_cnt <= LW'(LOST_FRAMES - 1);
            end
          end
          ST_COAST: begin
            if (bus.track_valid) begin
              state <= ST_TRACK;
              cx    <= cx_trk;
              cy    <= cy_trk;
            end else if (frame_start) begin
              if (lost_cnt == '0) state <= ST_MANUAL;
              else                lost_cnt <= lost_cnt - 1'b1;
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

  // Shadows load the cycle after frame start, so they see that cycle's centre/mode update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q          <= 1'b0;
      bus.rect_left   <= CW'(H_ACT / 2) - HALF_W;
      bus.rect_right  <= CW'(H_ACT / 2) + HALF_W;
      bus.rect_top    <= CW'(V_ACT / 2) - HALF_H;
      bus.rect_bottom <= CW'(V_ACT / 2) + HALF_H;
      bus.rect_en     <= 1'b0;
      bus.track_mode  <= 1'b0;
    end else begin
      load_q <= frame_start;
      if (load_q) begin
        bus.rect_left   <= cx - HALF_W;
        bus.rect_right  <= cx + HALF_W;
        bus.rect_top    <= cy - HALF_H;
        bus.rect_bottom <= cy + HALF_H;
        bus.rect_en     <= (state != ST_OFF);
        bus.track_mode  <= (state == ST_TRACK) || (state == ST_COAST);
      end
    end
  end

endmodule

// File: tb/tb_rect_ctrl.sv
// Self-checking bench for rect_ctrl: a behavioural box/coordinate model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_rect_ctrl;

  localparam int H = 640, V = 480, BW = 64, BH = 48, MG = 10, ST = 4, LOST = 8;
  localparam int CXMIN = BW/2 + MG, CXMAX = H - 1 - BW/2 - MG;
  localparam int CYMIN = BH/2 + MG, CYMAX = V - 1 - BH/2 - MG;

  logic clk = 1'b0;
  logic rst = 1'b0;
  rect_ctrl_if b();

  rect_ctrl #(.H_ACT(H), .V_ACT(V), .BOX_W(BW), .BOX_H(BH), .MARGIN(MG),
              .STEP(ST), .LOST_FRAMES(LOST)) dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int trk_rate = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Behavioural model state: coordinates, centre, mode flags, published box.
  int m_x, m_y, m_cx, m_cy, m_coast;
  bit m_on, m_follow, m_seen, m_pend, m_vs_prev, m_hr_prev;
  int m_left, m_right, m_top, m_bot;
  bit m_en, m_tm;
  bit s_rst, s_vs, s_hr, s_ck, s_up, s_dn, s_lf, s_rt, s_fl, s_tv, s_fs, s_le;
  int s_tx, s_ty;

  always @(posedge clk) begin
    s_rst = rst; s_vs = b.per_frame_vsync; s_hr = b.per_frame_href; s_ck = b.per_frame_clken;
    s_up = b.rect_up; s_dn = b.rect_down; s_lf = b.rect_left_key; s_rt = b.rect_right_key;
    s_fl = b.rect_flag; s_tv = b.track_valid; s_tx = int'(b.track_x); s_ty = int'(b.track_y);
    if (!s_rst) begin
      m_x = 0; m_y = 0; m_cx = H/2; m_cy = V/2; m_coast = -1;
      m_on = 0; m_follow = 0; m_seen = 0; m_pend = 0; m_vs_prev = 1; m_hr_prev = 0;
      m_left = H/2 - BW/2; m_right = H/2 + BW/2; m_top = V/2 - BH/2; m_bot = V/2 + BH/2;
      m_en = 0; m_tm = 0;
    end else begin
      s_fs = s_vs && !m_vs_prev;
      s_le = m_hr_prev && !s_hr;
      if (!s_hr) m_x = 0; else if (s_ck && m_x < H - 1) m_x++;
      if (s_vs) m_y = 0; else if (s_le && m_y < V - 1) m_y++;
      if (m_pend) begin
        m_left = m_cx - BW/2; m_right = m_cx + BW/2;
        m_top  = m_cy - BH/2; m_bot   = m_cy + BH/2;
        m_en = m_on; m_tm = m_follow;
      end
      if (!s_fl) begin
        m_on = 0; m_follow = 0; m_coast = -1;
      end else if (!m_follow) begin
        m_on = 1;
        if (s_tv) begin
          m_follow = 1; m_coast = -1;
          m_cx = clampi(s_tx, CXMIN, CXMAX); m_cy = clampi(s_ty, CYMIN, CYMAX);
        end else begin
          m_cx = clampi(m_cx + ST * (int'(s_rt) - int'(s_lf)), CXMIN, CXMAX);
          m_cy = clampi(m_cy + ST * (int'(s_dn) - int'(s_up)), CYMIN, CYMAX);
        end
      end else if (s_tv) begin
        m_coast = -1;
        m_cx = clampi(s_tx, CXMIN, CXMAX); m_cy = clampi(s_ty, CYMIN, CYMAX);
      end else if (s_fs) begin
        if (m_coast < 0) begin
          if (!m_seen) m_coast = LOST - 1;
        end else if (m_coast == 0) begin
          m_follow = 0; m_coast = -1;
        end else begin
          m_coast--;
        end
      end
      m_seen = s_fs ? s_tv : (m_seen || s_tv);
      m_pend = s_fs; m_vs_prev = s_vs; m_hr_prev = s_hr;
    end
    #3;
    if (rst) begin
      check("x_pos", b.x_pos, m_x);
      check("y_pos", b.y_pos, m_y);
      check("rect_left", b.rect_left, m_left);
      check("rect_right", b.rect_right, m_right);
      check("rect_top", b.rect_top, m_top);
      check("rect_bottom", b.rect_bottom, m_bot);
      check("rect_en", b.rect_en, m_en);
      check("track_mode", b.track_mode, m_tm);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    b.rect_up = 0; b.rect_down = 0; b.rect_left_key = 0; b.rect_right_key = 0;
    b.track_valid = 0;
  endtask

  task automatic rand_events();
    b.rect_up        = ($urandom_range(0, 7) == 0);
    b.rect_down      = ($urandom_range(0, 7) == 0);
    b.rect_left_key  = ($urandom_range(0, 7) == 0);
    b.rect_right_key = ($urandom_range(0, 7) == 0);
    b.track_valid    = ($urandom_range(0, 99) < trk_rate);
    b.track_x        = 10'($urandom_range(0, 1023));
    b.track_y        = 10'($urandom_range(0, 1023));
  endtask

  task automatic set_video(input bit vs, input bit hr, input bit ck);
    b.per_frame_vsync = vs; b.per_frame_href = hr; b.per_frame_clken = ck;
  endtask

  task automatic idle(input int n);
    set_video(0, 0, 0);
    repeat (n) cyc();
  endtask

  task automatic pulse(input bit u, input bit d, input bit l, input bit r);
    b.rect_up = u; b.rect_down = d; b.rect_left_key = l; b.rect_right_key = r;
    cyc();
    clear_events();
  endtask

  // Short frame: vsync pulse then n_lines lines of n_px cycles.
  task automatic drive_frame(input int n_lines, input int n_px, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      set_video(i < 2, 0, 0);
      if (rnd) rand_events();
      cyc();
    end
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < n_px + 2; p++) begin
        set_video(0, p < n_px, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (rnd) rand_events();
        cyc();
      end
    end
    clear_events();
    set_video(0, 0, 0);
  endtask

  task automatic check_box(input string tag, input int l, input int r, input int t, input int bt);
    check({tag, "_left"}, b.rect_left, l);
    check({tag, "_right"}, b.rect_right, r);
    check({tag, "_top"}, b.rect_top, t);
    check({tag, "_bottom"}, b.rect_bottom, bt);
  endtask

  initial begin
    set_video(0, 0, 0);
    clear_events();
    b.rect_flag = 0; b.track_x = '0; b.track_y = '0;
    repeat (3) cyc();
    check("rst_x", b.x_pos, 0);
    check("rst_y", b.y_pos, 0);
    check_box("rst", 288, 352, 216, 264);
    check("rst_en", b.rect_en, 0);
    check("rst_tm", b.track_mode, 0);
    rst = 1;
    idle(3);

    // Enable with no keys: default box published at frame start.
    b.rect_flag = 1;
    drive_frame(4, 12, 0);
    check_box("enable", 288, 352, 216, 264);
    check("enable_en", b.rect_en, 1);
    check("enable_tm", b.track_mode, 0);

    // Left key saturation at cx=42.
    repeat (100) begin pulse(0, 0, 1, 0); idle(1); end
    drive_frame(4, 12, 0);
    check_box("sat_left", 10, 74, 216, 264);

    // Opposing keys cancel; orthogonal keys both apply.
    pulse(1, 1, 0, 0);
    idle(2);
    pulse(1, 0, 0, 1);
    drive_frame(4, 12, 0);
    check_box("keys", 14, 78, 212, 260);

    // Track acquisition with clamping.
    b.track_x = 10'd600; b.track_y = 10'd5; b.track_valid = 1;
    cyc();
    clear_events();
    drive_frame(4, 12, 0);
    check_box("track", 565, 629, 10, 58);
    check("track_tm", b.track_mode, 1);

    // Track lost: eight coasting frames, then manual with the last centre.
    for (int f = 0; f < 8; f++) begin
      drive_frame(3, 8, 0);
      check("coast_tm", b.track_mode, 1);
      check("coast_left", b.rect_left, 565);
    end
    drive_frame(3, 8, 0);
    check("manual_tm", b.track_mode, 0);
    check("manual_en", b.rect_en, 1);
    check_box("manual", 565, 629, 10, 58);

    // Mid-frame key does not move the box until the next frame start.
    pulse(0, 0, 1, 0);
    idle(5);
    check("midkey_hold", b.rect_left, 565);
    drive_frame(3, 8, 0);
    check("midkey_next", b.rect_left, 561);

    // Full-width line and full-height frame for coordinate boundaries.
    set_video(1, 0, 0); cyc(); cyc();
    set_video(0, 0, 0); cyc(); cyc();
    for (int p = 0; p < 642; p++) begin
      set_video(0, 1, 1);
      #1;
      if (p == 0)   check("x_first", b.x_pos, 0);
      if (p == 639) check("x_last", b.x_pos, 639);
      if (p == 641) check("x_sat", b.x_pos, 639);
      cyc();
    end
    set_video(0, 0, 0); cyc();
    check("x_clear", b.x_pos, 0);
    cyc();
    for (int l = 1; l <= 480; l++) begin
      set_video(0, 1, 1);
      #1;
      if (l == 1)   check("y_boundary", b.y_pos, 1);
      if (l == 479) check("y_last", b.y_pos, 479);
      if (l == 480) check("y_sat", b.y_pos, 479);
      cyc();
      set_video(0, 0, 0); cyc();
    end
    set_video(1, 0, 0); cyc(); cyc();
    check("y_vsync_clear", b.y_pos, 0);
    idle(4);

    // Reset mid-frame: reset values held until the next vsync rise.
    rst = 0;
    cyc();
    check_box("midrst", 288, 352, 216, 264);
    check("midrst_en", b.rect_en, 0);
    cyc();
    rst = 1;
    pulse(0, 0, 0, 1);
    idle(20);
    check_box("postrst_hold", 288, 352, 216, 264);
    check("postrst_en", b.rect_en, 0);
    check("postrst_tm", b.track_mode, 0);
    drive_frame(3, 8, 0);
    check_box("postrst_frame", 292, 356, 216, 264);
    check("postrst_frame_en", b.rect_en, 1);

    // Randomised frames: keys, tracker bursts, overlay enable toggling.
    for (int f = 0; f < 40; f++) begin
      trk_rate = ($urandom_range(0, 2) == 0) ? 4 : 0;
      if ($urandom_range(0, 7) == 0) b.rect_flag = ~b.rect_flag;
      drive_frame(4, 12, 1);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
